// File: rtl/clock_pkg.sv
// Shared types and defaults for the clock sequencing controller.
// Mode encoding matches the 2-bit mode output seen by the display logic.
package clock_pkg;

    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    localparam int DEF_SEC_MAX  = 59;
    localparam int DEF_MIN_MAX  = 59;
    localparam int DEF_HOUR_MAX = 23;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2,
        MODE_SET_SEC  = 2'd3
    } mode_e;

    function automatic mode_e next_mode(input mode_e cur);
        case (cur)
            MODE_RUN:      next_mode = MODE_SET_HOUR;
            MODE_SET_HOUR: next_mode = MODE_SET_MIN;
            MODE_SET_MIN:  next_mode = MODE_SET_SEC;
            default:       next_mode = MODE_RUN;
        endcase
    endfunction

endpackage

// File: rtl/clock_time_ctrl_rise_edge.sv
// Rising-edge detector for a clk-synchronous level. History resets to 1 so a
// level already high when reset releases is not seen as an edge.
module rise_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pulse
);

    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= din;
        end
    end

    assign pulse = din & ~prev_q;

endmodule

// File: rtl/clock_time_ctrl.sv
// Sequencing controller for the sec/min/hour counter chain: run-mode carry/wrap
// pulses on the 1 Hz tick and the button-driven set-mode FSM.
//
// state         | meaning
// MODE_RUN      | tick advances time with carry into minutes and hours
// MODE_SET_HOUR | inc edge steps hours, tick only toggles blink
// MODE_SET_MIN  | inc edge steps minutes, tick only toggles blink
// MODE_SET_SEC  | inc edge steps seconds, tick only toggles blink
module clock_time_ctrl
    import clock_pkg::*;
#(
    parameter int SEC_MAX  = DEF_SEC_MAX,
    parameter int MIN_MAX  = DEF_MIN_MAX,
    parameter int HOUR_MAX = DEF_HOUR_MAX
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick_1hz,
    input  logic              btn_mode,
    input  logic              btn_inc,
    input  logic [SEC_W-1:0]  sec,
    input  logic [MIN_W-1:0]  minute,
    input  logic [HOUR_W-1:0] hour,
    output logic              count_sec,
    output logic              count_min,
    output logic              count_hour,
    output logic              set_sec,
    output logic              set_min,
    output logic              set_hour,
    output logic              clr_sec,
    output logic              clr_min,
    output logic              clr_hour,
    output logic [1:0]        mode,
    output logic              blink
);

    localparam logic [SEC_W-1:0]  SEC_LIM  = SEC_MAX[SEC_W-1:0];
    localparam logic [MIN_W-1:0]  MIN_LIM  = MIN_MAX[MIN_W-1:0];
    localparam logic [HOUR_W-1:0] HOUR_LIM = HOUR_MAX[HOUR_W-1:0];

    logic  mode_edge;
    logic  inc_edge;
    mode_e mode_q;

    rise_edge u_mode_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (btn_mode),
        .pulse (mode_edge)
    );

    rise_edge u_inc_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (btn_inc),
        .pulse (inc_edge)
    );

    // Out-of-range readback counts as "at max", so the next +1 wraps it to 0.
    logic sec_at_max;
    logic min_at_max;
    logic hour_at_max;

    assign sec_at_max  = (sec >= SEC_LIM);
    assign min_at_max  = (minute >= MIN_LIM);
    assign hour_at_max = (hour >= HOUR_LIM);

    logic inc_ok;
    assign inc_ok = inc_edge & ~mode_edge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= MODE_RUN;
            blink      <= 1'b0;
            count_sec  <= 1'b0;
            count_min  <= 1'b0;
            count_hour <= 1'b0;
            set_sec    <= 1'b0;
            set_min    <= 1'b0;
            set_hour   <= 1'b0;
            clr_sec    <= 1'b0;
            clr_min    <= 1'b0;
            clr_hour   <= 1'b0;
        end else begin
            count_sec  <= 1'b0;
            count_min  <= 1'b0;
            count_hour <= 1'b0;
            set_sec    <= 1'b0;
            set_min    <= 1'b0;
            set_hour   <= 1'b0;
            clr_sec    <= 1'b0;
            clr_min    <= 1'b0;
            clr_hour   <= 1'b0;

            if (mode_edge) begin
                mode_q <= next_mode(mode_q);
                blink  <= (next_mode(mode_q) != MODE_RUN);
            end else if (tick_1hz && mode_q != MODE_RUN) begin
                blink <= ~blink;
            end

            case (mode_q)
                MODE_RUN: begin
                    // A tick coinciding with a mode edge still advances time.
                    if (tick_1hz) begin
                        if (!sec_at_max) begin
                            count_sec <= 1'b1;
                        end else begin
                            clr_sec <= 1'b1;
                            if (!min_at_max) begin
                                count_min <= 1'b1;
                            end else begin
                                clr_min <= 1'b1;
                                if (!hour_at_max) count_hour <= 1'b1;
                                else              clr_hour   <= 1'b1;
                            end
                        end
                    end
                end
                MODE_SET_HOUR: begin
                    if (inc_ok) begin
                        if (!hour_at_max) set_hour <= 1'b1;
                        else              clr_hour <= 1'b1;
                    end
                end
                MODE_SET_MIN: begin
                    if (inc_ok) begin
                        if (!min_at_max) set_min <= 1'b1;
                        else             clr_min <= 1'b1;
                    end
                end
                default: begin
                    if (inc_ok) begin
                        if (!sec_at_max) set_sec <= 1'b1;
                        else             clr_sec <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign mode = mode_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Directed bench for clock_time_ctrl: expected outputs are queued as each step
// is driven and popped for comparison on the following falling edge.
module tb_clock_time_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [5:0] sec = '0;
    logic [5:0] minute = '0;
    logic [4:0] hour = '0;
    logic       count_sec, count_min, count_hour;
    logic       set_sec, set_min, set_hour;
    logic       clr_sec, clr_min, clr_hour;
    logic [1:0] mode;
    logic       blink;

    // Pulse vector bit order: count s/m/h, set s/m/h, clr s/m/h.
    localparam logic [8:0] NONE = 9'b000_000_000;
    localparam logic [8:0] C_S  = 9'b100_000_000;
    localparam logic [8:0] C_M  = 9'b010_000_000;
    localparam logic [8:0] C_H  = 9'b001_000_000;
    localparam logic [8:0] S_S  = 9'b000_100_000;
    localparam logic [8:0] S_M  = 9'b000_010_000;
    localparam logic [8:0] S_H  = 9'b000_001_000;
    localparam logic [8:0] K_S  = 9'b000_000_100;
    localparam logic [8:0] K_M  = 9'b000_000_010;
    localparam logic [8:0] K_H  = 9'b000_000_001;

    typedef struct {
        string      tag;
        logic [8:0] pulses;
        logic [1:0] mode;
        logic       blink;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;
    int   failed = 0;

    clock_time_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_1hz   (tick_1hz),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .sec        (sec),
        .minute     (minute),
        .hour       (hour),
        .count_sec  (count_sec),
        .count_min  (count_min),
        .count_hour (count_hour),
        .set_sec    (set_sec),
        .set_min    (set_min),
        .set_hour   (set_hour),
        .clr_sec    (clr_sec),
        .clr_min    (clr_min),
        .clr_hour   (clr_hour),
        .mode       (mode),
        .blink      (blink)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] obs_pulses();
        return {count_sec, count_min, count_hour, set_sec, set_min, set_hour,
                clr_sec, clr_min, clr_hour};
    endfunction

    task automatic push(input string tag, input logic [8:0] p, input logic [1:0] m,
                        input logic b);
        exp_t e;
        e.tag = tag;
        e.pulses = p;
        e.mode = m;
        e.blink = b;
        sb.push_back(e);
    endtask

    task automatic check_front();
        exp_t e;
        logic [8:0] op;
        total++;
        assert (sb.size() != 0) passed++;
        else begin
            failed++;
            $error("FAIL scoreboard_empty: observed 0 entries, expected at least 1");
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            op = obs_pulses();
            total++;
            assert (op === e.pulses) passed++;
            else begin
                failed++;
                $error("FAIL %s pulses: observed %b expected %b", e.tag, op, e.pulses);
            end
            total++;
            assert (mode === e.mode) passed++;
            else begin
                failed++;
                $error("FAIL %s mode: observed %0d expected %0d", e.tag, mode, e.mode);
            end
            total++;
            assert (blink === e.blink) passed++;
            else begin
                failed++;
                $error("FAIL %s blink: observed %b expected %b", e.tag, blink, e.blink);
            end
        end
    endtask

    // Called on a falling edge: drive, let one rising edge register, check.
    task automatic step(input logic t, input logic bm, input logic bi,
                        input logic [5:0] s, input logic [5:0] m, input logic [4:0] h,
                        input logic [8:0] ep, input logic [1:0] em, input logic eb,
                        input string tag);
        tick_1hz = t;
        btn_mode = bm;
        btn_inc  = bi;
        sec      = s;
        minute   = m;
        hour     = h;
        push(tag, ep, em, eb);
        @(posedge clk);
        @(negedge clk);
        check_front();
        tick_1hz = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        push("reset_state", NONE, 2'd0, 1'b0);
        check_front();
        rst_n = 1'b1;

        step(0, 0, 0, 10, 5, 3,  NONE,              0, 0, "idle_after_reset");
        step(1, 0, 0, 10, 5, 3,  C_S,               0, 0, "run_tick_sec");
        step(0, 0, 0, 11, 5, 3,  NONE,              0, 0, "pulse_one_cycle");
        step(1, 0, 0, 59, 59, 23, K_S | K_M | K_H,  0, 0, "run_full_wrap");
        step(1, 0, 0, 59, 59, 7, K_S | K_M | C_H,   0, 0, "run_hour_carry");
        step(1, 0, 0, 59, 30, 7, K_S | C_M,         0, 0, "run_min_carry");
        step(1, 0, 0, 63, 5, 7,  K_S | C_M,         0, 0, "run_sec_out_of_range");
        step(0, 0, 1, 10, 5, 7,  NONE,              0, 0, "run_inc_ignored");
        step(0, 0, 0, 10, 5, 7,  NONE,              0, 0, "run_inc_release");

        step(0, 1, 0, 10, 5, 22, NONE,              1, 1, "enter_set_hour");
        step(0, 0, 0, 10, 5, 22, NONE,              1, 1, "set_hour_idle");
        step(0, 0, 1, 10, 5, 22, S_H,               1, 1, "set_hour_inc");
        step(0, 0, 0, 10, 5, 23, NONE,              1, 1, "set_hour_release");
        step(0, 0, 1, 10, 5, 23, K_H,               1, 1, "set_hour_wrap");
        step(1, 0, 0, 59, 59, 0, NONE,              1, 0, "set_tick_blink_off");
        step(1, 0, 0, 10, 5, 0,  NONE,              1, 1, "set_tick_blink_on");
        step(0, 0, 1, 10, 5, 30, K_H,               1, 1, "set_hour_out_of_range");
        step(0, 0, 0, 10, 5, 0,  NONE,              1, 1, "set_hour_release2");

        step(0, 1, 1, 10, 5, 4,  NONE,              2, 1, "mode_beats_inc");
        step(0, 0, 0, 10, 20, 4, NONE,              2, 1, "set_min_idle");
        step(0, 0, 1, 10, 20, 4, S_M,               2, 1, "set_min_inc");
        step(0, 1, 0, 59, 20, 4, NONE,              3, 1, "enter_set_sec");
        step(0, 0, 0, 59, 20, 4, NONE,              3, 1, "set_sec_idle");
        step(0, 0, 1, 59, 20, 4, K_S,               3, 1, "set_sec_wrap");
        step(0, 1, 0, 10, 20, 4, NONE,              0, 0, "back_to_run");
        step(0, 0, 0, 10, 20, 4, NONE,              0, 0, "run_idle");
        step(0, 1, 0, 10, 20, 4, NONE,              1, 1, "run_to_set_hour");
        step(0, 0, 0, 10, 20, 4, NONE,              1, 1, "set_hour_idle2");

        // btn_mode held high across reset must not step the mode on release.
        btn_mode = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        push("held_reset_state", NONE, 2'd0, 1'b0);
        check_front();
        rst_n = 1'b1;
        step(0, 1, 0, 10, 20, 4, NONE,              0, 0, "held_btn_no_edge");
        step(0, 1, 0, 10, 20, 4, NONE,              0, 0, "held_btn_still");
        step(0, 0, 0, 10, 20, 4, NONE,              0, 0, "held_btn_release");

        // Reset asserted inside a tick cycle aborts the pending pulse.
        tick_1hz = 1'b1;
        btn_mode = 1'b0;
        sec = 6'd10;
        #2 rst_n = 1'b0;
        @(negedge clk);
        tick_1hz = 1'b0;
        rst_n = 1'b1;
        step(0, 0, 0, 10, 20, 4, NONE,              0, 0, "tick_reset_abort");
        step(1, 0, 0, 10, 20, 4, C_S,               0, 0, "run_after_abort");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, expected finish within 100000 time units");
        $fatal(1, "timeout");
    end

endmodule
